seq_detector_moore: RTL and testbench

// - Parametrised Moore-type serial pattern detector.
// - Successor to the fixed 5-state detector: any PAT_W-bit pattern, selectable overlap/non-overlap mode,

---
 rtl/seq_det_pkg.sv | 69 ++++++
 rtl/seq_detector_moore_sat_counter.sv | 37 +++
 rtl/seq_detector_moore.sv | 109 ++++++++++
 tb/tb_seq_detector_moore.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared helpers for the serial pattern detector:
//   - clog2 / state_w : width of the state index for a PAT_W-bit pattern
//   - build_delta     : elaboration-time KMP next-state table, flattened
// The table holds 2*(MAX_PAT_W+1) entries of DELTA_EW bits each. Entry
// (k*2 + b) is the next state when in state S[k] and bit b is accepted.
// ---------------------------------------------------------------------------
package seq_det_pkg;

    localparam int MAX_PAT_W = 32;
    localparam int DELTA_EW  = 8;
    localparam int TBL_W     = 2 * (MAX_PAT_W + 1) * DELTA_EW;

    typedef logic [DELTA_EW-1:0] delta_entry_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // States S0..S[pat_w] need pat_w+1 codes.
    function automatic int state_w(input int pat_w);
        return clog2(pat_w + 1);
    endfunction

    // delta(k,b) = longest j such that the first j pattern bits equal the
    // last j bits of (first k pattern bits, b). pattern[pat_w-1] is the first
    // bit on the wire; s[idx] below is the idx-th bit of that string.
    function automatic logic [TBL_W-1:0] build_delta(input logic [MAX_PAT_W-1:0] pattern,
                                                     input int pat_w);
        logic [TBL_W-1:0] tbl;
        int               best;
        int               idx;
        logic             ok;
        logic             sb;
        tbl = '0;
        for (int k = 0; k <= pat_w; k++) begin
            for (int b = 0; b < 2; b++) begin
                best = 0;
                for (int j = 1; j <= pat_w; j++) begin
                    if (j <= k + 1) begin
                        ok = 1'b1;
                        for (int m = 0; m < j; m++) begin
                            idx = k + 1 - j + m;
                            sb  = (idx == k) ? b[0] : pattern[pat_w - 1 - idx];
                            if (sb != pattern[pat_w - 1 - m]) begin
                                ok = 1'b0;
                            end
                        end
                        if (ok) begin
                            best = j;
                        end
                    end
                end
                tbl[(k * 2 + b) * DELTA_EW +: DELTA_EW] = best[DELTA_EW-1:0];
            end
        end
        return tbl;
    endfunction

endpackage

// File: rtl/seq_detector_moore_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with asynchronous reset and synchronous clear.
// Ports:
//   clk   in   rising-edge clock
//   reset in   asynchronous, active-high
//   inc   in   add one unless already at all-ones
//   clr   in   synchronous clear, wins over inc
//   q     out  W-bit count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] MAX_VAL = '1;

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != MAX_VAL)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/seq_detector_moore.sv
// ---------------------------------------------------------------------------
// seq_detector_moore
// Moore serial pattern detector. The state index equals the number of
// pattern bits matched so far; transitions come from a KMP table built at
// elaboration, so any PAT_W-bit pattern is handled without hand-written
// states. Outputs are decoded from the registered state only.
// Handshake: in_bit is consumed on a rising edge only when in_valid is high;
// there is no backpressure. clear outranks in_valid and discards in_bit.
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high
//   clear        in   synchronous clear of state and match counter
//   in_valid     in   qualifies in_bit
//   in_bit       in   serial data, PATTERN[PAT_W-1] expected first
//   match        out  high while in the full-match state
//   match_count  out  saturating count of full-match entries
//   progress     out  current state index (doubles as FSM debug view)
// ---------------------------------------------------------------------------
module seq_detector_moore
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      in_valid,
    input  logic                      in_bit,
    output logic                      match,
    output logic [CNT_W-1:0]          match_count,
    output logic [state_w(PAT_W)-1:0] progress
);

    localparam int                   SW      = state_w(PAT_W);
    localparam int                   NCODES  = 2 ** SW;
    localparam logic [SW-1:0]        FULL    = SW'(PAT_W);
    localparam logic [MAX_PAT_W-1:0] PAT_EXT = MAX_PAT_W'(PATTERN);
    localparam logic [TBL_W-1:0]     DELTA   = build_delta(PAT_EXT, PAT_W);

    logic [SW-1:0] r_state;
    logic [SW-1:0] w_next_state;
    logic [SW-1:0] w_lookup_state;
    logic          w_count_inc;

    // Table covers every code the register can hold; codes above PAT_W map
    // to S0 so the lookup never indexes outside the array.
    logic [SW-1:0] w_delta [0:NCODES-1][0:1];

    for (genvar k = 0; k < NCODES; k++) begin : g_state
        for (genvar b = 0; b < 2; b++) begin : g_bit
            if (k <= PAT_W) begin : g_used
                assign w_delta[k][b] = DELTA[(k * 2 + b) * DELTA_EW +: SW];
            end else begin : g_unused
                assign w_delta[k][b] = '0;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= '0;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        // Without overlap a completed match restarts detection as if from S0.
        w_lookup_state = r_state;
        if ((r_state == FULL) && !OVERLAP) begin
            w_lookup_state = '0;
        end

        w_next_state = r_state;
        if (clear) begin
            w_next_state = '0;
        end else if (r_state > FULL) begin
            w_next_state = '0;
        end else if (in_valid) begin
            w_next_state = w_delta[w_lookup_state][in_bit];
        end

        // Only an accepted bit landing in FULL counts; holding FULL while
        // in_valid is low is not a new match.
        w_count_inc = in_valid && !clear && (w_next_state == FULL);
    end

    // Moore output decode
    always_comb begin
        match    = (r_state == FULL);
        progress = r_state;
    end

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (w_count_inc),
        .clr  (clear),
        .q    (match_count)
    );

endmodule

// File: tb/tb_seq_detector_moore.sv
// ---------------------------------------------------------------------------
// tb_seq_detector_moore
// Five detector instances share one stimulus stream:
//   0: 1011 overlap      1: 1011 no-overlap   2: 0000 overlap
//   3: 0000 no-overlap   4: 1011 overlap, 2-bit counter
// A history-based model (longest pattern prefix that ends the accepted
// bit history) is compared against every instance on each falling edge;
// directed literal checks pin the expected behaviour of the model.
// ---------------------------------------------------------------------------
module tb_seq_detector_moore;

    localparam int NI = 5;

    // Clock / reset
    logic clk      = 1'b0;
    logic reset    = 1'b0;
    logic clear    = 1'b0;
    logic in_valid = 1'b0;
    logic in_bit   = 1'b0;

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] exp_q[$];

    // DUT outputs
    logic       match_a, match_b, match_c, match_d, match_e;
    logic [7:0] cnt_a, cnt_b, cnt_c, cnt_d;
    logic [1:0] cnt_e;
    logic [2:0] prog_a, prog_b, prog_c, prog_d, prog_e;

    seq_detector_moore #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
        .match(match_a), .match_count(cnt_a), .progress(prog_a));
    seq_detector_moore #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_b (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
        .match(match_b), .match_count(cnt_b), .progress(prog_b));
    seq_detector_moore #(.PAT_W(4), .PATTERN(4'b0000), .OVERLAP(1'b1), .CNT_W(8)) u_c (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
        .match(match_c), .match_count(cnt_c), .progress(prog_c));
    seq_detector_moore #(.PAT_W(4), .PATTERN(4'b0000), .OVERLAP(1'b0), .CNT_W(8)) u_d (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
        .match(match_d), .match_count(cnt_d), .progress(prog_d));
    seq_detector_moore #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_e (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
        .match(match_e), .match_count(cnt_e), .progress(prog_e));

    int d_match [NI];
    int d_cnt   [NI];
    int d_prog  [NI];

    always_comb begin
        d_match[0] = int'(match_a); d_cnt[0] = int'(cnt_a); d_prog[0] = int'(prog_a);
        d_match[1] = int'(match_b); d_cnt[1] = int'(cnt_b); d_prog[1] = int'(prog_b);
        d_match[2] = int'(match_c); d_cnt[2] = int'(cnt_c); d_prog[2] = int'(prog_c);
        d_match[3] = int'(match_d); d_cnt[3] = int'(cnt_d); d_prog[3] = int'(prog_d);
        d_match[4] = int'(match_e); d_cnt[4] = int'(cnt_e); d_prog[4] = int'(prog_e);
    end

    // Scoreboard check
    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model
    function automatic logic [3:0] cfg_pat(input int i);
        return (i == 2 || i == 3) ? 4'b0000 : 4'b1011;
    endfunction

    function automatic bit cfg_ovl(input int i);
        return (i != 1) && (i != 3);
    endfunction

    function automatic int cfg_max(input int i);
        return (i == 4) ? 3 : 255;
    endfunction

    logic [31:0] m_hist  [NI];
    int          m_len   [NI];
    int          m_prog  [NI];
    int          m_cnt   [NI];
    int          m_match [NI];

    // Longest j <= 4 such that the first j pattern bits are the last j
    // accepted bits.
    function automatic int longest(input logic [31:0] hist, input int len, input logic [3:0] pat);
        int          best;
        logic [31:0] mask;
        logic [31:0] pw;
        best = 0;
        pw   = 32'(pat);
        for (int j = 1; j <= 4; j++) begin
            if (j <= len) begin
                mask = (32'd1 << j) - 32'd1;
                if ((hist & mask) == (pw >> (4 - j))) best = j;
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_hist[i]  = '0;
            m_len[i]   = 0;
            m_prog[i]  = 0;
            m_cnt[i]   = 0;
            m_match[i] = 0;
        end
    endtask

    task automatic model_bit(input int i, input logic b);
        if ((m_match[i] != 0) && !cfg_ovl(i)) begin
            m_hist[i] = '0;
            m_len[i]  = 0;
        end
        m_hist[i] = {m_hist[i][30:0], b};
        if (m_len[i] < 32) m_len[i]++;
        m_prog[i]  = longest(m_hist[i], m_len[i], cfg_pat(i));
        m_match[i] = (m_prog[i] == 4) ? 1 : 0;
        if ((m_match[i] != 0) && (m_cnt[i] < cfg_max(i))) m_cnt[i]++;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset || clear) begin
            model_reset();
        end else if (in_valid) begin
            for (int i = 0; i < NI; i++) model_bit(i, in_bit);
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            check($sformatf("cyc_match[%0d]", i), d_match[i], m_match[i]);
            check($sformatf("cyc_count[%0d]", i), d_cnt[i], m_cnt[i]);
            check($sformatf("cyc_progress[%0d]", i), d_prog[i], m_prog[i]);
        end
    end

    // Driver tasks
    task automatic step(input logic v, input logic b);
        in_valid = v;
        in_bit   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear(input logic b);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_bit   = b;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
    endtask

    // Directed stimulus
    initial begin
        logic [6:0]  s1;
        logic [13:0] e1;
        logic [15:0] e2;
        logic [15:0] s4;
        logic [1:0]  e;
        int          nm;

        #1 reset = 1'b1;
        #1;
        check("rst_match", int'(match_a), 0);
        check("rst_count", int'(cnt_a), 0);
        check("rst_progress", int'(prog_a), 0);
        check("rst_count_e", int'(cnt_e), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // 1,0,1,1,0,1,1 : pairs are {overlap, no-overlap} match per bit
        s1 = 7'b1011011;
        e1 = 14'b00_00_00_11_00_00_10;
        for (int k = 0; k < 7; k++) exp_q.push_back(e1[2 * (6 - k) +: 2]);
        for (int k = 6; k >= 0; k--) begin
            step(1'b1, s1[k]);
            e = exp_q.pop_front();
            check("p1_match_ovl", int'(match_a), int'(e[1]));
            check("p1_match_novl", int'(match_b), int'(e[0]));
        end
        check("p1_count_ovl", int'(cnt_a), 2);
        check("p1_count_novl", int'(cnt_b), 1);
        check("p1_progress_ovl", int'(prog_a), 4);
        // After the match at bit 4, bits 0,1,1 leave only a trailing '1'.
        check("p1_progress_novl", int'(prog_b), 1);

        // Clear with a 0 on the wire: the 0000 detector must not take it.
        do_clear(1'b0);
        check("clr_progress_0000", int'(prog_c), 0);
        check("clr_count", int'(cnt_a), 0);

        // Eight zeros : pairs are {0000 overlap, 0000 no-overlap}
        e2 = 16'b00_00_00_11_10_10_10_11;
        for (int k = 0; k < 8; k++) exp_q.push_back(e2[2 * (7 - k) +: 2]);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0);
            e = exp_q.pop_front();
            check("p2_match_ovl", int'(match_c), int'(e[1]));
            check("p2_match_novl", int'(match_d), int'(e[0]));
        end
        check("p2_count_ovl", int'(cnt_c), 5);
        check("p2_count_novl", int'(cnt_d), 2);

        // Gaps in in_valid
        do_clear(1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        check("p3_progress_pre", int'(prog_a), 2);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'($urandom_range(0, 1)));
            check("p3_progress_hold", int'(prog_a), 2);
        end
        step(1'b1, 1'b1);
        check("p3_progress_3", int'(prog_a), 3);
        step(1'b1, 1'b1);
        check("p3_match", int'(match_a), 1);
        check("p3_count", int'(cnt_a), 1);
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'($urandom_range(0, 1)));
            check("p3_match_held", int'(match_a), 1);
            check("p3_count_held", int'(cnt_a), 1);
        end
        step(1'b1, 1'b0);
        check("p3_match_drop", int'(match_a), 0);
        check("p3_progress_after", int'(prog_a), 2);
        check("p3_count_after", int'(cnt_a), 1);

        // Five overlapping matches into a 2-bit counter
        do_clear(1'b0);
        s4 = 16'b1011011011011011;
        nm = 0;
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, s4[16 - k]);
            if ((k >= 4) && (((k - 4) % 3) == 0)) begin
                nm++;
                check("p4_match", int'(match_e), 1);
                check("p4_count_sat", int'(cnt_e), (nm < 3) ? nm : 3);
            end
        end
        check("p4_count_wide", int'(cnt_a), 5);
        // Clear while a 1 is offered: progress must stay 0, not 1.
        do_clear(1'b1);
        check("p4_clr_count", int'(cnt_e), 0);
        check("p4_clr_progress", int'(prog_e), 0);
        check("p4_clr_progress_a", int'(prog_a), 0);
        check("p4_clr_match", int'(match_e), 0);

        // Asynchronous reset mid-pattern
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
        in_valid = 1'b0;
        check("p5_progress_pre", int'(prog_a), 3);
        check("p5_count_pre", int'(cnt_a), 1);
        #2 reset = 1'b1;
        #1;
        check("p5_async_match", int'(match_a), 0);
        check("p5_async_progress", int'(prog_a), 0);
        check("p5_async_count", int'(cnt_a), 0);
        #1 reset = 1'b0;
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b1);
        check("p5_resume_match", int'(match_a), 1);
        check("p5_resume_count", int'(cnt_a), 1);
        check("p5_resume_progress", int'(prog_a), 4);
        step(1'b0, 1'b0);

        // Final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
